cache_mem_arbiter: RTL and testbench

- Shares one word-serial main-memory port between two cache controllers: port 0 is the data cache, port 1 is the instruction cache.
- Each requester asks for a whole-line transfer: either a refill (read) or a writeback (write) of 2^LINE_ADDR_LEN words.
- The arbiter grants one line transfer at a time, using round-robin arbitration.
- For each granted transfer it sequences the per-word memory commands, routes read data back to the owner, and pulses that owner's completion flag.
- Sits between the cache miss FSMs and the main memory model, below the WB pipeline stage.

---
 rtl/cache_pkg.sv | 19 +
 rtl/rr_arbiter2.sv | 13 +
 rtl/cache_mem_arbiter.sv | 128 ++++++++++++
 tb/tb_cache_mem_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and constants for the cache memory arbiter
package cache_pkg;

  localparam int LINE_ADDR_LEN_DEF = 3;
  localparam int PORT_D = 0;
  localparam int PORT_I = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic int words_per_line(input int line_addr_len);
    return 1 << line_addr_len;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-input round-robin pick, one-hot result
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       rr_ptr,
  output logic [1:0] pick
);

  always_comb begin
    pick = req;
    if (req == 2'b11) pick = rr_ptr ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - shares one word-serial memory port between D- and I-cache line transfers
module cache_mem_arbiter
  import cache_pkg::*;
#(
  parameter int LINE_ADDR_LEN = LINE_ADDR_LEN_DEF,
  parameter int ADDR_W        = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               req,
  input  logic [1:0]               req_we,
  input  logic [ADDR_W-1:0]        req_addr0,
  input  logic [ADDR_W-1:0]        req_addr1,
  input  logic [31:0]              wr_data0,
  input  logic [31:0]              wr_data1,
  output logic [LINE_ADDR_LEN-1:0] wr_idx,
  output logic [1:0]               gnt,
  output logic [1:0]               rd_valid,
  output logic [LINE_ADDR_LEN-1:0] rd_idx,
  output logic [31:0]              rd_data,
  output logic [1:0]               done,
  output logic                     mem_cmd_valid,
  input  logic                     mem_cmd_ready,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [31:0]              mem_wdata,
  input  logic                     mem_rvalid,
  input  logic [31:0]              mem_rdata,
  output logic                     busy,
  output logic                     proto_err
);

  localparam int CW = LINE_ADDR_LEN + 1;
  localparam logic [LINE_ADDR_LEN-1:0] LAST_IDX = LINE_ADDR_LEN'(words_per_line(LINE_ADDR_LEN) - 1);
  localparam logic [CW-1:0] WPL_CNT = CW'(words_per_line(LINE_ADDR_LEN));
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'((1 << (LINE_ADDR_LEN + 2)) - 1);

  state_t                   state;
  logic                     owner;
  logic                     we;
  logic                     rr_ptr;
  logic [ADDR_W-1:0]        base;
  logic [LINE_ADDR_LEN-1:0] issue_cnt;
  logic [CW-1:0]            resp_cnt;
  logic                     proto_err_q;

  logic [1:0]               pick;
  logic [ADDR_W-1:0]        sel_addr;
  logic                     cmd_fire;
  logic                     last_fire;
  logic                     read_ok;
  logic                     rsp_fire;
  logic [CW-1:0]            resp_next;

  rr_arbiter2 u_rr (
    .req    (req),
    .rr_ptr (rr_ptr),
    .pick   (pick)
  );

  // A response is legal only while a read command is outstanding; a latency-0
  // return for the command accepted this same cycle counts as outstanding.
  always_comb begin
    sel_addr  = (pick == 2'b10) ? req_addr1 : req_addr0;
    cmd_fire  = (state == S_ISSUE) && mem_cmd_ready;
    last_fire = cmd_fire && (issue_cnt == LAST_IDX);
    read_ok   = 1'b0;
    if (!we && state == S_DRAIN) read_ok = 1'b1;
    if (!we && state == S_ISSUE) read_ok = resp_cnt < ({1'b0, issue_cnt} + CW'(mem_cmd_ready));
    rsp_fire  = mem_rvalid && read_ok;
    resp_next = resp_cnt + CW'(rsp_fire);
  end

  assign busy          = (state != S_IDLE);
  assign gnt           = busy ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign done          = (state == S_DONE) ? gnt : 2'b00;
  assign mem_cmd_valid = (state == S_ISSUE);
  assign mem_we        = mem_cmd_valid && we;
  assign mem_addr      = mem_cmd_valid ? (base | ADDR_W'({issue_cnt, 2'b00})) : '0;
  assign wr_idx        = issue_cnt;
  assign mem_wdata     = mem_cmd_valid ? (owner ? wr_data1 : wr_data0) : '0;
  assign rd_valid      = rsp_fire ? gnt : 2'b00;
  assign rd_idx        = rsp_fire ? resp_cnt[LINE_ADDR_LEN-1:0] : '0;
  assign rd_data       = rsp_fire ? mem_rdata : '0;
  assign proto_err     = proto_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      owner       <= 1'b0;
      we          <= 1'b0;
      rr_ptr      <= 1'b0;
      base        <= '0;
      issue_cnt   <= '0;
      resp_cnt    <= '0;
      proto_err_q <= 1'b0;
    end else begin
      if (mem_rvalid && !read_ok) proto_err_q <= 1'b1;
      case (state)
        S_IDLE: begin
          if (req != 2'b00) begin
            owner     <= (pick == 2'b10);
            we        <= (pick == 2'b10) ? req_we[1] : req_we[0];
            base      <= sel_addr & ~LINE_MASK;
            issue_cnt <= '0;
            resp_cnt  <= '0;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (cmd_fire) issue_cnt <= issue_cnt + LINE_ADDR_LEN'(1);
          resp_cnt <= resp_next;
          if (last_fire) state <= (we || resp_next == WPL_CNT) ? S_DONE : S_DRAIN;
        end
        S_DRAIN: begin
          resp_cnt <= resp_next;
          if (resp_next == WPL_CNT) state <= S_DONE;
        end
        S_DONE: begin
          rr_ptr <= ~owner;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - self-checking bench for cache_mem_arbiter
module tb_cache_mem_arbiter;

  localparam int LAL = 3;
  localparam int WPL = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [1:0]     req = 2'b00;
  logic [1:0]     req_we = 2'b00;
  logic [31:0]    req_addr0 = '0;
  logic [31:0]    req_addr1 = '0;
  logic [31:0]    wr_data0, wr_data1;
  logic [LAL-1:0] wr_idx;
  logic [1:0]     gnt, rd_valid, done;
  logic [LAL-1:0] rd_idx;
  logic [31:0]    rd_data;
  logic           mem_cmd_valid, mem_we, busy, proto_err;
  logic           mem_cmd_ready = 1'b0;
  logic [31:0]    mem_addr, mem_wdata;
  logic           mem_rvalid = 1'b0;
  logic [31:0]    mem_rdata = '0;

  logic [31:0] pat0 = '0, pat1 = '0;
  assign wr_data0 = pat0 + 32'(wr_idx);
  assign wr_data1 = pat1 + 32'(wr_idx);

  cache_mem_arbiter #(.LINE_ADDR_LEN(LAL), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .wr_data0(wr_data0), .wr_data1(wr_data1), .wr_idx(wr_idx),
    .gnt(gnt), .rd_valid(rd_valid), .rd_idx(rd_idx), .rd_data(rd_data), .done(done),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .busy(busy), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  int lat = 2;
  int ready_mode = 0;
  bit force_rv = 0;
  bit mrr = 0;
  int keep [2] = '{0, 0};
  int first_valid_cyc = -1;
  int done_cyc = -1;
  bit prev_stall = 0;
  logic [31:0] prev_addr, prev_wdata;

  // memory response pipeline and observed / expected transaction logs
  int          due_q[$];
  logic [31:0] dat_q[$];
  logic [31:0] cmd_addr[$], cmd_data[$], exp_addr[$], exp_data[$];
  logic        cmd_we[$], exp_we[$];
  logic [1:0]  rd_port[$], exp_rd_port[$], done_log[$], exp_done[$];
  int          rd_idx_log[$], exp_rd_idx[$];
  logic [31:0] rd_dat_log[$], exp_rd_dat[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    cmd_addr.delete(); cmd_data.delete(); cmd_we.delete();
    exp_addr.delete(); exp_data.delete(); exp_we.delete();
    rd_port.delete(); rd_idx_log.delete(); rd_dat_log.delete();
    exp_rd_port.delete(); exp_rd_idx.delete(); exp_rd_dat.delete();
    done_log.delete(); exp_done.delete();
    due_q.delete(); dat_q.delete();
    first_valid_cyc = -1; done_cyc = -1; prev_stall = 0;
  endtask

  // Reference: a line transfer is 8 words at base+4i; refills return mem_word
  // in index order; completion re-points round robin at the other port.
  task automatic expect_xfer(input int p);
    logic [31:0] b, pat;
    logic w;
    b   = (p == 1 ? req_addr1 : req_addr0) & ~32'(WPL * 4 - 1);
    pat = (p == 1) ? pat1 : pat0;
    w   = req_we[p];
    for (int i = 0; i < WPL; i++) begin
      exp_addr.push_back(b + 32'(4 * i));
      exp_we.push_back(w);
      exp_data.push_back(pat + 32'(i));
      if (!w) begin
        exp_rd_port.push_back(p == 1 ? 2'b10 : 2'b01);
        exp_rd_idx.push_back(i);
        exp_rd_dat.push_back(mem_word(b + 32'(4 * i)));
      end
    end
    exp_done.push_back(p == 1 ? 2'b10 : 2'b01);
    mrr = (p == 0);
  endtask

  task automatic cycle();
    bit from_q;
    @(posedge clk);
    #1;
    cyc++;
    case (ready_mode)
      0: mem_cmd_ready = 1'b1;
      1: mem_cmd_ready = (cyc % 2) == 0;
      default: mem_cmd_ready = 1'($urandom_range(0, 1));
    endcase
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    from_q = 0;
    if (force_rv) begin
      mem_rvalid = 1'b1;
      mem_rdata = $urandom;
    end else if (due_q.size() > 0 && due_q[0] <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata = dat_q[0];
      from_q = 1;
    end
    #1;
    if (mem_cmd_valid) begin
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      if (prev_stall) begin
        check("stall_addr", mem_addr, prev_addr);
        if (mem_we) check("stall_wdata", mem_wdata, prev_wdata);
      end
      prev_stall = !mem_cmd_ready;
      prev_addr = mem_addr;
      prev_wdata = mem_wdata;
      if (mem_cmd_ready) begin
        cmd_addr.push_back(mem_addr);
        cmd_we.push_back(mem_we);
        cmd_data.push_back(mem_wdata);
        if (!mem_we) begin
          due_q.push_back(cyc + lat);
          dat_q.push_back(mem_word(mem_addr));
        end
      end
    end else begin
      prev_stall = 0;
    end
    if (!mem_rvalid && due_q.size() > 0 && due_q[0] <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata = dat_q[0];
      from_q = 1;
      #1;
    end
    if (from_q) begin
      void'(due_q.pop_front());
      void'(dat_q.pop_front());
    end
    if (rd_valid != 2'b00) begin
      rd_port.push_back(rd_valid);
      rd_idx_log.push_back(int'(rd_idx));
      rd_dat_log.push_back(rd_data);
    end
    if (done != 2'b00) begin
      done_log.push_back(done);
      if (done_cyc < 0) done_cyc = cyc;
      for (int p = 0; p < 2; p++)
        if (done[p]) begin
          if (keep[p] > 0) keep[p]--;
          else req[p] = 1'b0;
        end
    end
  endtask

  task automatic run(input int n_done, input int budget);
    int k;
    k = 0;
    while (!(done_log.size() >= n_done && !busy && req == 2'b00) && k < budget) begin
      cycle();
      k++;
    end
    check("run_within_budget", k < budget, 1);
  endtask

  task automatic compare_logs(input string tag);
    check({tag, "_ncmd"}, cmd_addr.size(), exp_addr.size());
    for (int i = 0; i < cmd_addr.size() && i < exp_addr.size(); i++) begin
      check({tag, "_addr"}, cmd_addr[i], exp_addr[i]);
      check({tag, "_we"}, cmd_we[i], exp_we[i]);
      if (exp_we[i]) check({tag, "_wdata"}, cmd_data[i], exp_data[i]);
    end
    check({tag, "_nrd"}, rd_port.size(), exp_rd_port.size());
    for (int i = 0; i < rd_port.size() && i < exp_rd_port.size(); i++) begin
      check({tag, "_rd_port"}, rd_port[i], exp_rd_port[i]);
      check({tag, "_rd_idx"}, rd_idx_log[i], exp_rd_idx[i]);
      check({tag, "_rd_data"}, rd_dat_log[i], exp_rd_dat[i]);
    end
    check({tag, "_ndone"}, done_log.size(), exp_done.size());
    for (int i = 0; i < done_log.size() && i < exp_done.size(); i++)
      check({tag, "_done"}, done_log[i], exp_done[i]);
    clear_logs();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, gnt, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_cmd_valid"}, mem_cmd_valid, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_wr_idx"}, wr_idx, 0);
    check({tag, "_rd_valid"}, rd_valid, 0);
    check({tag, "_rd_idx"}, rd_idx, 0);
    check({tag, "_rd_data"}, rd_data, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_proto_err"}, proto_err, 0);
  endtask

  initial begin
    int req_cyc;
    logic [1:0] r;
    int first;

    // reset state
    #2;
    check_all_zero("reset");
    #10;
    rst_n = 1'b1;
    mrr = 0;

    // both ports request together from reset; port 0 re-requests once
    req_we = 2'b10; req_addr0 = 32'h0000_2000; req_addr1 = 32'h0000_3004;
    pat0 = 32'h100; pat1 = 32'h200; lat = 1; ready_mode = 0;
    expect_xfer(0); expect_xfer(1); expect_xfer(0);
    keep[0] = 1; req = 2'b11;
    run(3, 200);
    compare_logs("both");

    // port 0 refill, latency 2, ready always
    req_we = 2'b00; req_addr0 = 32'h0000_1234; lat = 2; ready_mode = 0;
    expect_xfer(0);
    req_cyc = cyc; req = 2'b01;
    run(1, 100);
    check("refill_first_cmd_latency", first_valid_cyc, req_cyc + 1);
    compare_logs("refill");

    // port 1 writeback with ready toggling
    req_we = 2'b10; req_addr1 = 32'h0000_0040; pat1 = 32'hA0; ready_mode = 1;
    expect_xfer(1);
    req = 2'b10;
    run(1, 100);
    compare_logs("wb_toggle");
    check("wb_proto_err", proto_err, 0);

    // best-case write timing: 8 command cycles then DONE
    req_we = 2'b01; req_addr0 = 32'h0000_8000; pat0 = 32'h5000; ready_mode = 0;
    expect_xfer(0);
    req_cyc = cyc; req = 2'b01;
    run(1, 100);
    check("wb_first_cmd", first_valid_cyc, req_cyc + 1);
    check("wb_done_cycle", done_cyc, req_cyc + 9);
    compare_logs("wb_fast");

    // last command and 8th response in the same cycle
    req_we = 2'b00; req_addr1 = 32'h0001_0F00; lat = 0; ready_mode = 0;
    expect_xfer(1);
    req_cyc = cyc; req = 2'b10;
    run(1, 100);
    check("lat0_done_cycle", done_cyc, req_cyc + 9);
    compare_logs("lat0");

    // reset mid-burst at issue_cnt=3
    req_we = 2'b00; req_addr0 = 32'h0000_4444; lat = 2; ready_mode = 0;
    req = 2'b01;
    for (int k = 0; k < 50 && cmd_addr.size() < 3; k++) cycle();
    check("midrst_three_cmds", cmd_addr.size(), 3);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    mem_rvalid = 1'b0;
    #1;
    check_all_zero("midrst");
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      check("midrst_no_done", done, 0);
    end
    #3;
    rst_n = 1'b1;
    mrr = 0;
    clear_logs();
    expect_xfer(0);
    run(1, 100);
    compare_logs("after_rst");

    // randomized traffic against the round-robin model
    for (int it = 0; it < 8; it++) begin
      r = 2'($urandom_range(1, 3));
      req_we = 2'($urandom);
      req_addr0 = $urandom; req_addr1 = $urandom;
      pat0 = $urandom; pat1 = $urandom;
      lat = $urandom_range(1, 3); ready_mode = 2;
      if (r == 2'b11) begin
        first = mrr ? 1 : 0;
        expect_xfer(first);
        expect_xfer(1 - first);
      end else begin
        expect_xfer(r == 2'b10 ? 1 : 0);
      end
      req = r;
      run(r == 2'b11 ? 2 : 1, 400);
      compare_logs("rand");
    end
    check("rand_proto_err", proto_err, 0);

    // stray response while idle
    ready_mode = 0; lat = 1;
    force_rv = 1;
    cycle();
    check("idle_rv_no_rd_valid", rd_valid, 0);
    force_rv = 0;
    cycle();
    check("idle_rv_proto_err", proto_err, 1);
    req_we = 2'b00; req_addr1 = 32'h0000_0100;
    expect_xfer(1);
    req = 2'b10;
    run(1, 100);
    compare_logs("post_err");
    check("proto_err_sticky", proto_err, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("proto_err_cleared", proto_err, 0);
    #5;
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
